// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write port, two read ports and the clear handshake.
interface register_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic                  RegW;
   logic [ADDR_W-1:0]     DR;
   logic [DATA_W-1:0]     Reg_in;
   logic [DATA_W/8-1:0]   WMASK;
   logic [ADDR_W-1:0]     SR1;
   logic [ADDR_W-1:0]     SR2;
   logic [DATA_W-1:0]     ReadReg1;
   logic [DATA_W-1:0]     ReadReg2;
   logic                  CLR_req;
   logic                  CLR_busy;

   modport master (
      output RegW, DR, Reg_in, WMASK, SR1, SR2, CLR_req,
      input  ReadReg1, ReadReg2, CLR_busy
   );

   modport slave (
      input  RegW, DR, Reg_in, WMASK, SR1, SR2, CLR_req,
      output ReadReg1, ReadReg2, CLR_busy
   );
endinterface

// File: rtl/register_file_mp.sv
// Byte-masked 1W/2R register file with a one-entry-per-cycle clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining WRITE_BYPASS_EN.
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic               CLK,
   input  logic               RESET,
   register_file_mp_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic                wr_ok;
   logic [DATA_W-1:0]   wr_data;
   logic [DATA_W-1:0]   rd1, rd2;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [NB-1:0]     mask
   );
      merge_bytes = old_v;
      for (int b = 0; b < NB; b++) begin
         if (mask[b]) merge_bytes[8*b +: 8] = new_v[8*b +: 8];
      end
   endfunction

   // Writes are only honoured while idle, and never to a hardwired entry 0.
   assign wr_ok   = bus.RegW && (state_q == IDLE) &&
                    !((ZERO_REG != 0) && (bus.DR == '0));
   assign wr_data = merge_bytes(mem_q[bus.DR], bus.Reg_in, bus.WMASK);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      case (state_q)
         IDLE: begin
            if (wr_ok) mem_d[bus.DR] = wr_data;
            if (bus.CLR_req) begin
               state_d = SWEEP;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         SWEEP: begin
            mem_d[idx_q] = '0;
            idx_d        = idx_q + 1'b1;
            if (idx_q == {ADDR_W{1'b1}}) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   always_comb begin
      rd1 = mem_q[bus.SR1];
      rd2 = mem_q[bus.SR2];
`ifdef WRITE_BYPASS_EN
      if (wr_ok && (bus.SR1 == bus.DR)) rd1 = wr_data;
      if (wr_ok && (bus.SR2 == bus.DR)) rd2 = wr_data;
`endif
      if ((ZERO_REG != 0) && (bus.SR1 == '0)) rd1 = '0;
      if ((ZERO_REG != 0) && (bus.SR2 == '0)) rd2 = '0;
   end

   assign bus.ReadReg1 = rd1;
   assign bus.ReadReg2 = rd2;
   assign bus.CLR_busy = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (ZERO_REG=0 and ZERO_REG=1) share one stimulus stream.
module tb_register_file_mp;
   logic CLK = 1'b0;
   logic RESET = 1'b0;
   int tests = 0;
   int fails = 0;

   register_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifc0 ();
   register_file_mp_if #(.DATA_W(32), .ADDR_W(4)) ifc1 ();

   register_file_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(ifc0));
   register_file_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(ifc1));

   assign ifc1.RegW    = ifc0.RegW;
   assign ifc1.DR      = ifc0.DR;
   assign ifc1.Reg_in  = ifc0.Reg_in;
   assign ifc1.WMASK   = ifc0.WMASK;
   assign ifc1.SR1     = ifc0.SR1;
   assign ifc1.SR2     = ifc0.SR2;
   assign ifc1.CLR_req = ifc0.CLR_req;

   always #5 CLK = ~CLK;

   // Reference model: entry contents plus the edge index at which the last clear was accepted.
   logic [31:0] m0 [16];
   logic [31:0] m1 [16];
   int edge_n = 0;
   int clr_k  = -100;

   function automatic logic [31:0] apply_mask(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] mask);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   function automatic logic busy_exp();
      return (edge_n >= clr_k) && (edge_n < clr_k + 16);
   endfunction

   function automatic logic [31:0] exp_rd(input bit zr, input logic [3:0] sr);
      logic [31:0] v;
      v = zr ? m1[sr] : m0[sr];
`ifdef WRITE_BYPASS_EN
      if (ifc0.RegW && !busy_exp() && (sr == ifc0.DR) && !(zr && ifc0.DR == 4'd0))
         v = apply_mask(v, ifc0.Reg_in, ifc0.WMASK);
`endif
      if (zr && sr == 4'd0) v = 32'h0;
      return v;
   endfunction

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 16; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
         clr_k = -100;
      end else begin
         edge_n++;
         if (edge_n > clr_k && edge_n <= clr_k + 16) begin
            m0[edge_n - clr_k - 1] = 32'h0;
            m1[edge_n - clr_k - 1] = 32'h0;
         end else begin
            if (ifc0.RegW) begin
               m0[ifc0.DR] = apply_mask(m0[ifc0.DR], ifc0.Reg_in, ifc0.WMASK);
               if (ifc0.DR != 4'd0) m1[ifc0.DR] = apply_mask(m1[ifc0.DR], ifc0.Reg_in, ifc0.WMASK);
            end
            if (ifc0.CLR_req) clr_k = edge_n;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(posedge CLK) begin
      #1;
      chk("cmp0_rd1", ifc0.ReadReg1, exp_rd(1'b0, ifc0.SR1));
      chk("cmp0_rd2", ifc0.ReadReg2, exp_rd(1'b0, ifc0.SR2));
      chk("cmp0_busy", {31'h0, ifc0.CLR_busy}, {31'h0, busy_exp()});
      chk("cmp1_rd1", ifc1.ReadReg1, exp_rd(1'b1, ifc1.SR1));
      chk("cmp1_rd2", ifc1.ReadReg2, exp_rd(1'b1, ifc1.SR2));
      chk("cmp1_busy", {31'h0, ifc1.CLR_busy}, {31'h0, busy_exp()});
   end

   task automatic drive(input logic w, input logic [3:0] dr, input logic [31:0] din,
                        input logic [3:0] mask, input logic [3:0] s1, input logic [3:0] s2,
                        input logic clr);
      @(negedge CLK);
      ifc0.RegW = w; ifc0.DR = dr; ifc0.Reg_in = din; ifc0.WMASK = mask;
      ifc0.SR1 = s1; ifc0.SR2 = s2; ifc0.CLR_req = clr;
   endtask

   int busy_cnt;

   initial begin
      ifc0.RegW = 1'b0; ifc0.DR = 4'd0; ifc0.Reg_in = 32'h0; ifc0.WMASK = 4'h0;
      ifc0.SR1 = 4'd0; ifc0.SR2 = 4'd0; ifc0.CLR_req = 1'b0;
      repeat (2) @(negedge CLK);
      chk("reset_busy", {31'h0, ifc0.CLR_busy}, 32'h0);
      RESET = 1'b1;

      for (int s = 0; s < 16; s++) begin
         drive(1'b0, 4'd0, 32'h0, 4'h0, s[3:0], 4'(15 - s), 1'b0);
         #1;
         chk("reset_read0", ifc0.ReadReg1, 32'h0);
         chk("reset_read1", ifc1.ReadReg2, 32'h0);
      end

      // Byte-masked merge and same-cycle read behaviour.
      drive(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 4'd5, 4'd5, 1'b0);
      drive(1'b1, 4'd5, 32'h11223344, 4'h5, 4'd5, 4'd5, 1'b0);
      #1;
`ifdef WRITE_BYPASS_EN
      chk("same_cycle_rd", ifc0.ReadReg2, 32'hDE22BE44);
`else
      chk("same_cycle_rd", ifc0.ReadReg2, 32'hDEADBEEF);
`endif
      drive(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 4'd5, 4'd5, 1'b0);
      #1;
      chk("masked_merge", ifc0.ReadReg1, 32'hDE22BE44);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd5, 4'd5, 1'b0);
      #1;
      chk("zero_mask_nochg", ifc1.ReadReg1, 32'hDE22BE44);

      // Entry 0 behaviour with and without ZERO_REG.
      drive(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 4'd0, 4'd15, 1'b0);
      drive(1'b1, 4'd15, 32'h12345678, 4'hF, 4'd0, 4'd15, 1'b0);
      #1;
      chk("zr1_entry0", ifc1.ReadReg1, 32'h0);
      chk("zr0_entry0", ifc0.ReadReg1, 32'hFFFFFFFF);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd15, 1'b0);
      #1;
      chk("zr1_entry15", ifc1.ReadReg2, 32'h12345678);

      // Fill, then a single-cycle clear pulse.
      for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 32'h100 + 32'(i), 4'hF, 4'd3, 4'd2, 1'b0);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd3, 4'd2, 1'b0);
      #1;
      chk("fill_entry3", ifc0.ReadReg1, 32'h103);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd3, 4'd2, 1'b1);
      @(posedge CLK); #1;
      busy_cnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (ifc0.CLR_busy) busy_cnt++;
         if (j == 3) chk("entry3_before", ifc0.ReadReg1, 32'h103);
         if (j == 4) chk("entry3_after", ifc0.ReadReg1, 32'h0);
         drive((j == 8), 4'd2, 32'hAAAA5555, 4'hF, 4'd3, 4'd2, 1'b0);
         @(posedge CLK); #1;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'd16);
      chk("sweep_wr_dropped", ifc0.ReadReg2, 32'h0);
      for (int s = 0; s < 16; s++) begin
         drive(1'b0, 4'd0, 32'h0, 4'h0, s[3:0], s[3:0], 1'b0);
         #1;
         chk("swept_zero", ifc0.ReadReg1, 32'h0);
      end

      // Reset mid-sweep, with CLR_req held high throughout.
      for (int i = 8; i < 16; i++) drive(1'b1, 4'(i), 32'h100 + 32'(i), 4'hF, 4'd8, 4'd15, 1'b0);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd8, 4'd15, 1'b1);
      repeat (6) @(posedge CLK);
      @(negedge CLK);
      chk("pre_rst_entry8", ifc0.ReadReg1, 32'h108);
      chk("pre_rst_busy", {31'h0, ifc0.CLR_busy}, 32'h1);
      #2;
      RESET = 1'b0;
      #1;
      chk("rst_busy", {31'h0, ifc0.CLR_busy}, 32'h0);
      chk("rst_entry8", ifc0.ReadReg1, 32'h0);
      chk("rst_entry15", ifc1.ReadReg2, 32'h0);
      for (int s = 0; s < 16; s++) begin
         ifc0.SR1 = s[3:0];
         #0.2;
         chk("rst_all_zero", ifc0.ReadReg1, 32'h0);
      end
      @(negedge CLK);
      RESET = 1'b1;

      // Held request: back-to-back sweeps, re-accepted one edge after each finishes.
      repeat (40) drive(1'b1, 4'd7, 32'h0BADF00D, 4'hF, 4'd7, 4'd1, 1'b1);
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd7, 4'd1, 1'b0);
      repeat (20) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
